buffered_fork_operator: RTL and testbench

//  Next-generation dataflow node for the async req/ack fabric. It gathers one operand per input

---
 rtl/async_op_pkg.sv | 56 +++++
 rtl/bfo_result_fifo.sv | 54 +++++
 rtl/buffered_fork_operator.sv | 145 ++++++++++++++
 tb/tb_buffered_fork_operator.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_op_pkg.sv
// Shared op encodings and elaboration helpers for async req/ack dataflow nodes.
// Also used by the fabric-level generator.
package async_op_pkg;

    typedef enum logic [3:0] {
        OP_REG, OP_IN, OP_OUT,
        OP_ADDI, OP_SUBI, OP_MULI,
        OP_ADD, OP_SUB, OP_MUL,
        OP_BAD
    } op_e;

    localparam int OP_NAME_W = 64;
    localparam int HS_PULSE_CYCLES = 1;

    localparam logic [OP_NAME_W-1:0] NM_REG  = "reg";
    localparam logic [OP_NAME_W-1:0] NM_IN   = "in";
    localparam logic [OP_NAME_W-1:0] NM_OUT  = "out";
    localparam logic [OP_NAME_W-1:0] NM_ADDI = "addi";
    localparam logic [OP_NAME_W-1:0] NM_SUBI = "subi";
    localparam logic [OP_NAME_W-1:0] NM_MULI = "muli";
    localparam logic [OP_NAME_W-1:0] NM_ADD  = "add";
    localparam logic [OP_NAME_W-1:0] NM_SUB  = "sub";
    localparam logic [OP_NAME_W-1:0] NM_MUL  = "mul";

    function automatic op_e op_decode(input logic [OP_NAME_W-1:0] name,
                                      input int n_in);
        op_e r;
        r = OP_BAD;
        if (n_in == 1) begin
            if (name == NM_REG)       r = OP_REG;
            else if (name == NM_IN)   r = OP_IN;
            else if (name == NM_OUT)  r = OP_OUT;
            else if (name == NM_ADDI) r = OP_ADDI;
            else if (name == NM_SUBI) r = OP_SUBI;
            else if (name == NM_MULI) r = OP_MULI;
        end else if (n_in >= 2 && n_in <= 3) begin
            if (name == NM_ADD)       r = OP_ADD;
            else if (name == NM_SUB)  r = OP_SUB;
            else if (name == NM_MUL)  r = OP_MUL;
        end
        return r;
    endfunction

    function automatic bit op_legal(input logic [OP_NAME_W-1:0] name,
                                    input int n_in);
        return op_decode(name, n_in) != OP_BAD;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bfo_result_fifo.sv
// Result FIFO for buffered_fork_operator: async reset, memory cleared on reset.
module bfo_result_fifo
    import async_op_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    // Depth is a power of two, so the MSB of the count is the full flag.
    assign full    = cnt_q[AW];
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/buffered_fork_operator.sv
// Dataflow node: gathers one operand per channel, applies OP, forks results from a FIFO.
// Define BUFFERED_FORK_OPERATOR_STATS_EN to add fire_count and stall_cycles outputs.
module buffered_fork_operator
    import async_op_pkg::*;
#(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     INPUT_SIZE  = 2,
    parameter int                     OUTPUT_SIZE = 1,
    parameter int                     FIFO_DEPTH  = 2,
    parameter logic [OP_NAME_W-1:0]   OP          = NM_ADD,
    parameter logic [DATA_WIDTH-1:0]  IMMEDIATE   = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [INPUT_SIZE-1:0]            req_l,
    input  logic [INPUT_SIZE-1:0]            ack_l,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
    input  logic [OUTPUT_SIZE-1:0]           req_r,
    output logic [OUTPUT_SIZE-1:0]           ack_r,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [clog2(FIFO_DEPTH):0]       fifo_count
`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
    ,
    output logic [31:0]                      fire_count,
    output logic [31:0]                      stall_cycles
`endif
);

    localparam op_e OPC = op_decode(OP, INPUT_SIZE);

    if (!op_legal(OP, INPUT_SIZE) || OUTPUT_SIZE < 1 || OUTPUT_SIZE > 8 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        HS_PULSE_CYCLES != 1) begin : g_bad_cfg
        $error("buffered_fork_operator: illegal parameter set");
    end

    logic [INPUT_SIZE-1:0]  req_l_q, req_l_d;
    logic [INPUT_SIZE-1:0]  has_q, has_d;
    logic [DATA_WIDTH-1:0]  opnd_q [INPUT_SIZE];
    logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
    logic [OUTPUT_SIZE-1:0] served_q, served_d;
    logic [DATA_WIDTH-1:0]  res;
    logic                   full, empty, fire, pop;

    assign fire  = (&has_q) & ~full;
    assign pop   = &served_q;
    assign req_l = req_l_q;
    assign ack_r = ack_r_q;

    always_comb begin
        res = opnd_q[0];
        case (OPC)
            OP_ADDI: res = opnd_q[0] + IMMEDIATE;
            OP_SUBI: res = opnd_q[0] - IMMEDIATE;
            OP_MULI: res = opnd_q[0] * IMMEDIATE;
            OP_ADD:  for (int i = 1; i < INPUT_SIZE; i++) res = res + opnd_q[i];
            OP_SUB:  for (int i = 1; i < INPUT_SIZE; i++) res = res - opnd_q[i];
            OP_MUL:  for (int i = 1; i < INPUT_SIZE; i++) res = res * opnd_q[i];
            default: res = opnd_q[0];
        endcase
    end

    // A held operand (has=1) keeps its request low; acks against it are dropped.
    always_comb begin
        has_d   = has_q;
        req_l_d = req_l_q;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (fire) begin
                has_d[i] = 1'b0;
            end else if (ack_l[i] && !has_q[i]) begin
                has_d[i]   = 1'b1;
                req_l_d[i] = 1'b0;
            end else if (!has_q[i] && !req_l_q[i]) begin
                req_l_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        served_d = served_q;
        ack_r_d  = '0;
        if (pop) begin
            served_d = '0;
        end else begin
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                if (req_r[j] && !served_q[j] && !ack_r_q[j] && !empty) begin
                    ack_r_d[j]  = 1'b1;
                    served_d[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_l_q  <= '0;
            has_q    <= '0;
            ack_r_q  <= '0;
            served_q <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) opnd_q[i] <= '0;
        end else begin
            req_l_q  <= req_l_d;
            has_q    <= has_d;
            ack_r_q  <= ack_r_d;
            served_q <= served_d;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                if (ack_l[i] && !has_q[i])
                    opnd_q[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    bfo_result_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .pop   (pop),
        .wdata (res),
        .rdata (dout),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
    logic [31:0] fire_cnt_q, stall_q;

    assign fire_count   = fire_cnt_q;
    assign stall_cycles = stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            if (fire) fire_cnt_q <= fire_cnt_q + 32'd1;
            if ((&has_q) && full) stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_buffered_fork_operator.sv
// Directed bench for buffered_fork_operator: gather, fork, backpressure, wrap, reset.
module tb_buffered_fork_operator;
    import async_op_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // u1: 2-in add, 3 consumers
    logic [1:0]  req_l1, ack_l1 = '0;
    logic [63:0] din1 = '0;
    logic [2:0]  req_r1 = '0, ack_r1;
    logic [31:0] dout1;
    logic [1:0]  cnt1;
    // u2: 1-in addi 2, 2 consumers
    logic [0:0]  req_l2, ack_l2 = '0;
    logic [31:0] din2 = '0;
    logic [1:0]  req_r2 = '0, ack_r2;
    logic [31:0] dout2;
    logic [1:0]  cnt2;
    // u3: 1-in subi 2
    logic [0:0]  req_l3, ack_l3 = '0;
    logic [31:0] din3 = '0;
    logic [0:0]  req_r3 = '0, ack_r3;
    logic [31:0] dout3;
    logic [1:0]  cnt3;
    // u4: 3-in mul
    logic [2:0]  req_l4, ack_l4 = '0;
    logic [95:0] din4 = '0;
    logic [0:0]  req_r4 = '0, ack_r4;
    logic [31:0] dout4;
    logic [1:0]  cnt4;
`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
    logic [31:0] fc1, fc2, fc3, fc4, sc1, sc2, sc3, sc4;
`endif

    buffered_fork_operator #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(3),
        .FIFO_DEPTH(2), .OP(NM_ADD), .IMMEDIATE(32'd0)) u1 (
        .clk(clk), .rst(rst), .req_l(req_l1), .ack_l(ack_l1), .din(din1),
        .req_r(req_r1), .ack_r(ack_r1), .dout(dout1), .fifo_count(cnt1)
`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
        , .fire_count(fc1), .stall_cycles(sc1)
`endif
    );

    buffered_fork_operator #(.DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(2),
        .FIFO_DEPTH(2), .OP(NM_ADDI), .IMMEDIATE(32'd2)) u2 (
        .clk(clk), .rst(rst), .req_l(req_l2), .ack_l(ack_l2), .din(din2),
        .req_r(req_r2), .ack_r(ack_r2), .dout(dout2), .fifo_count(cnt2)
`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
        , .fire_count(fc2), .stall_cycles(sc2)
`endif
    );

    buffered_fork_operator #(.DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(1),
        .FIFO_DEPTH(2), .OP(NM_SUBI), .IMMEDIATE(32'd2)) u3 (
        .clk(clk), .rst(rst), .req_l(req_l3), .ack_l(ack_l3), .din(din3),
        .req_r(req_r3), .ack_r(ack_r3), .dout(dout3), .fifo_count(cnt3)
`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
        , .fire_count(fc3), .stall_cycles(sc3)
`endif
    );

    buffered_fork_operator #(.DATA_WIDTH(32), .INPUT_SIZE(3), .OUTPUT_SIZE(1),
        .FIFO_DEPTH(2), .OP(NM_MUL), .IMMEDIATE(32'd0)) u4 (
        .clk(clk), .rst(rst), .req_l(req_l4), .ack_l(ack_l4), .din(din4),
        .req_r(req_r4), .ack_r(ack_r4), .dout(dout4), .fifo_count(cnt4)
`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
        , .fire_count(fc4), .stall_cycles(sc4)
`endif
    );

    task automatic send1(input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = ((req_l1 & m) == m);
        end
        check("u1_req_wait", ok, 1);
        ack_l1 = m;
        din1   = {b, a};
        @(negedge clk);
        ack_l1 = '0;
    endtask

    task automatic send2(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = req_l2[0];
        end
        check("u2_req_wait", ok, 1);
        ack_l2 = 1'b1;
        din2   = a;
        @(negedge clk);
        ack_l2 = 1'b0;
    endtask

    task automatic send3(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = req_l3[0];
        end
        check("u3_req_wait", ok, 1);
        ack_l3 = 1'b1;
        din3   = a;
        @(negedge clk);
        ack_l3 = 1'b0;
    endtask

    task automatic send4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = (req_l4 == 3'b111);
        end
        check("u4_req_wait", ok, 1);
        ack_l4 = 3'b111;
        din4   = {c, b, a};
        @(negedge clk);
        ack_l4 = '0;
    endtask

    bit          found;
    int          n_seen, extra, pops;
    logic [2:0]  acc;
    logic [31:0] exp2 [3];

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req_l", req_l1, 0);
        check("rst_ack_r", ack_r1, 0);
        check("rst_count", cnt1, 0);
        check("rst_dout", dout1, 0);
        check("rst_dout_u2", dout2, 0);

        // Test 1: 5+7 forked to three consumers, 2-cycle latency
        req_r1 = 3'b111;
        send1(2'b11, 32'd5, 32'd7);
        check("t1_n1_count", cnt1, 0);
        check("t1_n1_req_l", req_l1, 0);
        @(negedge clk);
        check("t1_n2_count", cnt1, 1);
        check("t1_n2_ack_r", ack_r1, 0);
        @(negedge clk);
        check("t1_n3_ack_r", ack_r1, 3'b111);
        check("t1_n3_dout", dout1, 12);
        check("t1_n3_req_l", req_l1, 2'b11);
        @(negedge clk);
        check("t1_n4_ack_r", ack_r1, 0);
        check("t1_n4_count", cnt1, 0);
        acc = '0;
        repeat (4) begin
            @(negedge clk);
            acc = acc | ack_r1;
        end
        check("t1_no_dup_ack", acc, 0);

        // Test 2: backpressure with FIFO full, then drain in order
        req_r2 = 2'b00;
        send2(32'd0);
        send2(32'd1);
        send2(32'd2);
        repeat (5) @(negedge clk);
        check("t2_full_count", cnt2, 2);
        check("t2_held_req_l", req_l2, 0);
        check("t2_head", dout2, 2);
        exp2[0] = 32'd2;
        exp2[1] = 32'd3;
        exp2[2] = 32'd4;
        n_seen = 0;
        req_r2 = 2'b11;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack_r2 != 2'b00) begin
                check("t2_ack_both", ack_r2, 2'b11);
                if (n_seen < 3) check("t2_dout_seq", dout2, exp2[n_seen]);
                n_seen++;
            end
        end
        check("t2_tokens", n_seen, 3);
        check("t2_drained", cnt2, 0);

        // Test 3: slow second consumer holds the head
        req_r2 = 2'b01;
        send2(32'd10);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = (ack_r2 != 2'b00);
        end
        check("t3_ack0_seen", found, 1);
        check("t3_ack0_only", ack_r2, 2'b01);
        check("t3_ack0_dout", dout2, 12);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack_r2 != 2'b00) extra++;
        end
        check("t3_no_reack", extra, 0);
        check("t3_no_pop", cnt2, 1);
        check("t3_dout_hold", dout2, 12);
        req_r2 = 2'b11;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = (ack_r2 != 2'b00);
        end
        check("t3_ack1_seen", found, 1);
        check("t3_ack1_only", ack_r2, 2'b10);
        check("t3_ack1_dout", dout2, 12);
        @(negedge clk);
        check("t3_popped", cnt2, 0);

        // Test 4: modulo arithmetic
        req_r3 = 1'b1;
        send3(32'd1);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = ack_r3[0];
        end
        check("t4_subi_seen", found, 1);
        check("t4_subi_wrap", dout3, 32'hFFFF_FFFF);
        req_r4 = 1'b1;
        send4(32'h1_0000, 32'h1_0000, 32'd3);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = ack_r4[0];
        end
        check("t4_mul_seen", found, 1);
        check("t4_mul_trunc", dout4, 0);
        send4(32'd2, 32'd3, 32'd4);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = ack_r4[0];
        end
        check("t4_mul_seen2", found, 1);
        check("t4_mul_24", dout4, 24);

        // Test 5: async reset with one token queued and a partial operand
        req_r1 = 3'b000;
        send1(2'b11, 32'd5, 32'd7);
        send1(2'b01, 32'd100, 32'd0);
        @(negedge clk);
        check("t5_pre_count", cnt1, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_req_l", req_l1, 0);
        check("t5_async_ack_r", ack_r1, 0);
        check("t5_async_count", cnt1, 0);
        check("t5_async_dout", dout1, 0);
        @(negedge clk);
        rst = 1'b0;
        req_r1 = 3'b111;
        send1(2'b11, 32'd1, 32'd2);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = (ack_r1 != 3'b000);
        end
        check("t5_fresh_seen", found, 1);
        check("t5_fresh_ack", ack_r1, 3'b111);
        check("t5_fresh_dout", dout1, 3);

`ifdef BUFFERED_FORK_OPERATOR_STATS_EN
        // Test 6: throttled consumer, counters after 5000 tokens
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_r2 = 2'b00;
        pops = 0;
        fork
            for (int t = 0; t < 5000; t++) send2(t[31:0]);
            for (int c = 0; c < 80000 && pops < 5000; c++) begin
                @(negedge clk);
                if (ack_r2[0]) begin
                    check("t6_dout", dout2, pops + 2);
                    pops++;
                end
                req_r2 = (c % 4 == 0) ? 2'b11 : 2'b00;
            end
        join
        check("t6_pops", pops, 5000);
        check("t6_fire_count", fc2, 5000);
        check("t6_stall_nz", (sc2 != 0), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
